// File: rtl/btn_cond.sv
`timescale 1ns/1ps
// ============================================================================
// btn_cond
// ----------------------------------------------------------------------------
// Multi-channel push-button conditioner for the DAPA2014 board top level.
// Every raw button goes through a 2-flop synchroniser and a counter-based
// debouncer, and produces one-cycle rise/fall strobes. A button-combination
// detector turns "hold these buttons together" into one clean, stretched,
// synchronous reset request per press.
//
// Parameters:
//   N_BTN      number of button channels (1..16)
//   DEB_W      width of each per-channel debounce counter
//   DEB_CYCLES cycles an input must differ from the stable level before it
//              is accepted (1..2^DEB_W-1)
//   RST_MASK   N_BTN-bit mask of buttons forming the reset combination;
//              an all-zero mask disables the detector
//   RST_LEN    length of the reset request pulse in cycles (1..255)
//
// Ports:
//   ext_clk     in   1      system clock, rising edge
//   reset       in   1      asynchronous, active-low reset
//   btn_in      in   N_BTN  raw asynchronous active-high buttons
//   btn_out     out  N_BTN  debounced stable level per channel
//   btn_rise    out  N_BTN  one-cycle strobe on btn_out 0->1
//   btn_fall    out  N_BTN  one-cycle strobe on btn_out 1->0
//   rst_req_out out  1      registered reset request, RST_LEN cycles long
// ============================================================================
module btn_cond #(
   parameter int               N_BTN      = 4,
   parameter int               DEB_W      = 16,
   parameter int               DEB_CYCLES = 50000,
   parameter logic [N_BTN-1:0] RST_MASK   = N_BTN'(4'b0011),
   parameter int               RST_LEN    = 16
) (
   input  logic             ext_clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_out,
   output logic [N_BTN-1:0] btn_rise,
   output logic [N_BTN-1:0] btn_fall,
   output logic             rst_req_out
);

   // Terminal value of a debounce counter. Reaching it means the synchronised
   // input has differed from btn_out for DEB_CYCLES consecutive cycles.
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

   // Value loaded into the pulse counter on entry to FIRE. The request stays
   // high while the counter walks from RCNT_LOAD down to zero inclusive.
   localparam logic [7:0]       RCNT_LOAD = 8'(RST_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      FIRE,
      WAIT_REL
   } combo_state_t;

   logic [N_BTN-1:0] s1;
   logic [N_BTN-1:0] s2;
   logic [DEB_W-1:0] cnt [N_BTN];

   combo_state_t     state;
   combo_state_t     state_next;
   logic [7:0]       rcnt;
   logic [7:0]       rcnt_next;
   logic             rst_req_next;
   logic [N_BTN-1:0] masked;
   logic             combo_full;

   // Two-stage synchroniser. The raw pins are asynchronous to ext_clk, so only
   // the second stage is allowed to feed any decision logic.
   always_ff @(posedge ext_clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;
      end
   end

   // Per-channel debouncer. Each counter only runs while the synchronised
   // input disagrees with the accepted level; any cycle of agreement clears
   // it, so a glitch shorter than DEB_CYCLES never reaches btn_out. The
   // counter is cleared on acceptance, so it can never wrap. The strobes are
   // registered alongside btn_out so they are high exactly in the cycle in
   // which the new level first appears.
   always_ff @(posedge ext_clk or negedge reset) begin
      if (!reset) begin
         btn_out  <= '0;
         btn_rise <= '0;
         btn_fall <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            btn_rise[i] <= 1'b0;
            btn_fall[i] <= 1'b0;
            if (s2[i] == btn_out[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
               btn_out[i]  <= s2[i];
               btn_rise[i] <= s2[i];
               btn_fall[i] <= ~s2[i];
               cnt[i]      <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // The detector only looks at the debounced levels of the masked buttons.
   // An all-zero mask would otherwise match permanently, so it disables the
   // detector outright.
   always_comb begin
      masked     = btn_out & RST_MASK;
      combo_full = (RST_MASK != '0) && (masked == RST_MASK);
   end

   // Combination detector state register. rst_req_out is registered here
   // rather than decoded from the state so the request line is glitch-free.
   always_ff @(posedge ext_clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         rcnt        <= '0;
         rst_req_out <= 1'b0;
      end else begin
         state       <= state_next;
         rcnt        <= rcnt_next;
         rst_req_out <= rst_req_next;
      end
   end

   // Combination detector next-state logic.
   // IDLE arms on the full combination and launches the pulse. FIRE keeps the
   // request high until the counter has been seen at zero, regardless of what
   // the buttons do meanwhile, so an early release cannot shorten the pulse.
   // WAIT_REL swallows the still-held combination and only re-arms once at
   // least one masked button has been released, giving one request per press.
   always_comb begin
      state_next   = state;
      rcnt_next    = rcnt;
      rst_req_next = 1'b0;
      case (state)
         IDLE: begin
            if (combo_full) begin
               state_next   = FIRE;
               rcnt_next    = RCNT_LOAD;
               rst_req_next = 1'b1;
            end
         end
         FIRE: begin
            if (rcnt == 8'd0) begin
               state_next   = WAIT_REL;
               rst_req_next = 1'b0;
            end else begin
               rcnt_next    = rcnt - 8'd1;
               rst_req_next = 1'b1;
            end
         end
         WAIT_REL: begin
            if (!combo_full) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            rcnt_next  = '0;
         end
      endcase
   end

endmodule
